// File: rtl/ebus_arb_mux_if.sv
// ebus_arb_mux_if -- bundle of the EBUS driver inputs and the registered
// EBUS outputs of ebus_arb_mux.
//   drv_driving  per-channel driving flag (bit i = channel i)
//   drv_data     flattened driver data, channel i at [i*WIDTH +: WIDTH]
//   ebus_data    registered bus data
//   ebus_valid   registered "some driver was active"
//   ebus_src     registered winning channel index
//   ebus_par     registered odd parity over ebus_data
// master: the driver side (tEBUSdriver outputs / bus consumers).
// slave:  the arbiter/mux itself.
interface ebus_arb_mux_if #(
  parameter int N_DRV = 30,
  parameter int WIDTH = 36
);
  localparam int SRC_W = (N_DRV > 1) ? $clog2(N_DRV) : 1;

  logic [N_DRV-1:0]       drv_driving;
  logic [N_DRV*WIDTH-1:0] drv_data;
  logic [WIDTH-1:0]       ebus_data;
  logic                   ebus_valid;
  logic [SRC_W-1:0]       ebus_src;
  logic                   ebus_par;

  modport master (
    output drv_driving, drv_data,
    input  ebus_data, ebus_valid, ebus_src, ebus_par
  );

  modport slave (
    input  drv_driving, drv_data,
    output ebus_data, ebus_valid, ebus_src, ebus_par
  );
endinterface

// File: rtl/ebus_arb_mux.sv
// ebus_arb_mux -- registered EBUS data mux for the KL10 top level.
// Selects the lowest-index active driver onto the EBUS, registers data,
// valid, source index and odd parity, and keeps diagnostic state about
// multi-driver contention and drivers that hold the bus too long.
// Ports:
//   clk              system clock
//   crobar_l         asynchronous active-low reset
//   bus              ebus_arb_mux_if.slave (driver inputs, bus outputs)
//   clr_diag         synchronous clear of the diagnostic state
//   conflict         registered pulse: >1 driver active in the sampled cycle
//   conflict_sticky  latched contention flag
//   conflict_mask    drv_driving captured at the first contention
//   conflict_cnt     saturating count of contention cycles
//   stuck            latched: one source drove STUCK_CYC consecutive cycles
module ebus_arb_mux #(
  parameter int N_DRV     = 30,
  parameter int WIDTH     = 36,
  parameter bit HOLD_IDLE = 1'b0,
  parameter int CNT_W     = 8,
  parameter int STUCK_CYC = 1024
) (
  input  logic             clk,
  input  logic             crobar_l,
  ebus_arb_mux_if.slave    bus,
  input  logic             clr_diag,
  output logic             conflict,
  output logic             conflict_sticky,
  output logic [N_DRV-1:0] conflict_mask,
  output logic [CNT_W-1:0] conflict_cnt,
  output logic             stuck
);
  localparam int SRC_W = $clog2(N_DRV);
  localparam int RUN_W = $clog2(STUCK_CYC + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STUCK_CYC);

  // ---------------------------------------------------------------------
  // Combinational selection
  // ---------------------------------------------------------------------
  logic [N_DRV-1:0] drv;
  logic [N_DRV-1:0] win_onehot;
  logic             any_active;
  logic             multi_active;

  assign drv = bus.drv_driving;
  // Two's-complement trick isolates the lowest set bit (fixed priority).
  assign win_onehot   = drv & (~drv + N_DRV'(1));
  assign any_active   = |drv;
  // Clearing the lowest set bit leaves something only if >=2 bits were set.
  assign multi_active = |(drv & (drv - N_DRV'(1)));

  logic [WIDTH-1:0] sel_data [N_DRV];
  logic [SRC_W-1:0] sel_idx  [N_DRV];

  // One-hot AND-OR mux: each channel contributes only when it is the winner.
  genvar gi;
  generate
    for (gi = 0; gi < N_DRV; gi++) begin : g_sel
      assign sel_data[gi] = win_onehot[gi] ? bus.drv_data[gi*WIDTH +: WIDTH] : '0;
      assign sel_idx[gi]  = win_onehot[gi] ? SRC_W'(gi) : '0;
    end
  endgenerate

  logic [WIDTH-1:0] win_data;
  logic [SRC_W-1:0] win_idx;

  always_comb begin
    win_data = '0;
    win_idx  = '0;
    for (int i = 0; i < N_DRV; i++) begin
      win_data = win_data | sel_data[i];
      win_idx  = win_idx  | sel_idx[i];
    end
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] ebus_data_reg,  ebus_data_next;
  logic             ebus_valid_reg;
  logic [SRC_W-1:0] ebus_src_reg,   ebus_src_next;
  logic             ebus_par_reg;
  logic             conflict_reg;
  logic             sticky_reg,     sticky_next;
  logic [N_DRV-1:0] mask_reg,       mask_next;
  logic [CNT_W-1:0] cnt_reg,        cnt_next;
  logic             stuck_reg,      stuck_next;
  logic [RUN_W-1:0] run_reg,        run_next;

  always_comb begin
    ebus_data_next = ebus_data_reg;
    ebus_src_next  = ebus_src_reg;
    run_next       = run_reg;
    sticky_next    = sticky_reg;
    mask_next      = mask_reg;
    cnt_next       = cnt_reg;
    stuck_next     = stuck_reg;

    // Data path
    if (any_active) begin
      ebus_data_next = win_data;
      ebus_src_next  = win_idx;
    end else if (!HOLD_IDLE) begin
      ebus_data_next = '0;
    end

    // Run counter: ebus_valid_reg/ebus_src_reg describe the previous
    // sampled cycle, so they tell us whether this is a continuation.
    if (!any_active) begin
      run_next = '0;
    end else if (!ebus_valid_reg || (win_idx != ebus_src_reg)) begin
      run_next = RUN_W'(1);
    end else if (run_reg != RUN_MAX) begin
      run_next = run_reg + RUN_W'(1);
    end

    // Diagnostics: clear first, then let new events override it.
    if (clr_diag) begin
      sticky_next = 1'b0;
      mask_next   = '0;
      cnt_next    = '0;
      stuck_next  = 1'b0;
    end

    if (multi_active) begin
      sticky_next = 1'b1;
      // Capture only the first contention since the last clear.
      if (!sticky_reg || clr_diag) begin
        mask_next = drv;
      end
      if (clr_diag) begin
        cnt_next = CNT_W'(1);
      end else if (cnt_reg != '1) begin
        cnt_next = cnt_reg + CNT_W'(1);
      end
    end

    if (run_next == RUN_MAX) begin
      stuck_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge crobar_l) begin
    if (!crobar_l) begin
      ebus_data_reg  <= '0;
      ebus_valid_reg <= 1'b0;
      ebus_src_reg   <= '0;
      ebus_par_reg   <= 1'b1;
      conflict_reg   <= 1'b0;
      sticky_reg     <= 1'b0;
      mask_reg       <= '0;
      cnt_reg        <= '0;
      stuck_reg      <= 1'b0;
      run_reg        <= '0;
    end else begin
      ebus_data_reg  <= ebus_data_next;
      ebus_valid_reg <= any_active;
      ebus_src_reg   <= ebus_src_next;
      ebus_par_reg   <= ~^ebus_data_next;
      conflict_reg   <= multi_active;
      sticky_reg     <= sticky_next;
      mask_reg       <= mask_next;
      cnt_reg        <= cnt_next;
      stuck_reg      <= stuck_next;
      run_reg        <= run_next;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.ebus_data    = ebus_data_reg;
  assign bus.ebus_valid   = ebus_valid_reg;
  assign bus.ebus_src     = ebus_src_reg;
  assign bus.ebus_par     = ebus_par_reg;
  assign conflict         = conflict_reg;
  assign conflict_sticky  = sticky_reg;
  assign conflict_mask    = mask_reg;
  assign conflict_cnt     = cnt_reg;
  assign stuck            = stuck_reg;
endmodule

// File: tb/tb_ebus_arb_mux.sv
// tb_ebus_arb_mux -- directed bench for ebus_arb_mux. Two instances share
// the same stimulus: dut0 with HOLD_IDLE=0, dut1 with HOLD_IDLE=1; both use
// CNT_W=4 and STUCK_CYC=8 so saturation and stuck detection are reachable.
module tb_ebus_arb_mux;
  localparam int N  = 30;
  localparam int W  = 36;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          crobar_l;
  logic          clr_diag;
  logic [N-1:0]  drv_driving;
  logic [N*W-1:0] drv_data;

  logic          conflict0, sticky0, stuck0;
  logic [N-1:0]  mask0;
  logic [CW-1:0] cnt0;
  logic          conflict1, sticky1, stuck1;
  logic [N-1:0]  mask1;
  logic [CW-1:0] cnt1;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ebus_arb_mux_if #(.N_DRV(N), .WIDTH(W)) bus0 ();
  ebus_arb_mux_if #(.N_DRV(N), .WIDTH(W)) bus1 ();

  assign bus0.drv_driving = drv_driving;
  assign bus0.drv_data    = drv_data;
  assign bus1.drv_driving = drv_driving;
  assign bus1.drv_data    = drv_data;

  ebus_arb_mux #(.N_DRV(N), .WIDTH(W), .HOLD_IDLE(1'b0), .CNT_W(CW), .STUCK_CYC(8)) dut0 (
    .clk(clk), .crobar_l(crobar_l), .bus(bus0), .clr_diag(clr_diag),
    .conflict(conflict0), .conflict_sticky(sticky0), .conflict_mask(mask0),
    .conflict_cnt(cnt0), .stuck(stuck0)
  );

  ebus_arb_mux #(.N_DRV(N), .WIDTH(W), .HOLD_IDLE(1'b1), .CNT_W(CW), .STUCK_CYC(8)) dut1 (
    .clk(clk), .crobar_l(crobar_l), .bus(bus1), .clr_diag(clr_diag),
    .conflict(conflict1), .conflict_sticky(sticky1), .conflict_mask(mask1),
    .conflict_cnt(cnt1), .stuck(stuck1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_ch(input int ch, input logic [W-1:0] val);
    drv_data[ch*W +: W] = val;
  endtask

  initial begin
    logic [W-1:0] d5, d3, d17, d0, d1;
    d5  = 36'o123456701234;
    d3  = 36'o111122223333;
    d17 = 36'o000000000007;
    d0  = 36'o707070707070;
    d1  = 36'o000011110000;

    crobar_l    = 1'b0;
    clr_diag    = 1'b0;
    drv_driving = '0;
    drv_data    = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst data",   64'(bus0.ebus_data),  64'd0);
    chk("rst par",    64'(bus0.ebus_par),   64'd1);
    chk("rst valid",  64'(bus0.ebus_valid), 64'd0);
    chk("rst src",    64'(bus0.ebus_src),   64'd0);
    chk("rst cnt",    64'(cnt0),            64'd0);
    chk("rst stuck",  64'(stuck0),          64'd0);
    crobar_l = 1'b1;

    // Single driver on channel 5
    set_ch(5, d5);
    drv_driving = 30'd1 << 5;
    cycle();
    chk("single data",  64'(bus0.ebus_data),  64'(d5));
    chk("single src",   64'(bus0.ebus_src),   64'd5);
    chk("single valid", 64'(bus0.ebus_valid), 64'd1);
    chk("single conf",  64'(conflict0),       64'd0);
    chk("single par",   64'(bus0.ebus_par),   64'(~^d5));

    // Contention on 3 and 17
    set_ch(3, d3);
    set_ch(17, d17);
    drv_driving = (30'd1 << 3) | (30'd1 << 17);
    cycle();
    chk("cont1 src",    64'(bus0.ebus_src),  64'd3);
    chk("cont1 data",   64'(bus0.ebus_data), 64'(d3));
    chk("cont1 pulse",  64'(conflict0),      64'd1);
    chk("cont1 mask",   64'(mask0),          64'h20008);
    chk("cont1 cnt",    64'(cnt0),           64'd1);
    chk("cont1 sticky", 64'(sticky0),        64'd1);
    drv_driving = '0;
    cycle();
    chk("idle conf",    64'(conflict0),       64'd0);
    chk("idle valid",   64'(bus0.ebus_valid), 64'd0);
    chk("idle data0",   64'(bus0.ebus_data),  64'd0);
    chk("idle data1",   64'(bus1.ebus_data),  64'(d3));
    chk("idle src",     64'(bus0.ebus_src),   64'd3);

    // Second contention on 0 and 1: mask unchanged
    set_ch(0, d0);
    set_ch(1, d1);
    drv_driving = 30'b11;
    cycle();
    chk("cont2 src",  64'(bus0.ebus_src),  64'd0);
    chk("cont2 data", 64'(bus0.ebus_data), 64'(d0));
    chk("cont2 mask", 64'(mask0),          64'h20008);
    chk("cont2 cnt",  64'(cnt0),           64'd2);

    // Idle and hold on channel 2
    set_ch(2, 36'o777);
    drv_driving = 30'd1 << 2;
    cycle();
    chk("ch2 data", 64'(bus0.ebus_data), 64'o777);
    drv_driving = '0;
    cycle();
    chk("hold0 data",  64'(bus0.ebus_data),  64'd0);
    chk("hold0 par",   64'(bus0.ebus_par),   64'd1);
    chk("hold0 valid", 64'(bus0.ebus_valid), 64'd0);
    chk("hold0 src",   64'(bus0.ebus_src),   64'd2);
    chk("hold1 data",  64'(bus1.ebus_data),  64'o777);
    chk("hold1 par",   64'(bus1.ebus_par),   64'd0);
    chk("hold1 valid", 64'(bus1.ebus_valid), 64'd0);

    // 20 contention cycles: counter saturates, channel 0 also goes stuck
    drv_driving = 30'b11;
    repeat (20) cycle();
    chk("sat cnt",    64'(cnt0),      64'd15);
    chk("sat pulse",  64'(conflict0), 64'd1);
    chk("sat stuck",  64'(stuck0),    64'd1);

    // clr_diag alone
    drv_driving = '0;
    clr_diag    = 1'b1;
    cycle();
    clr_diag = 1'b0;
    chk("clr sticky", 64'(sticky0), 64'd0);
    chk("clr mask",   64'(mask0),   64'd0);
    chk("clr cnt",    64'(cnt0),    64'd0);
    chk("clr stuck",  64'(stuck0),  64'd0);
    chk("clr conf",   64'(conflict0), 64'd0);

    // clr_diag together with contention
    drv_driving = (30'd1 << 4) | (30'd1 << 6);
    clr_diag    = 1'b1;
    cycle();
    clr_diag = 1'b0;
    chk("clrc cnt",    64'(cnt0),    64'd1);
    chk("clrc sticky", 64'(sticky0), 64'd1);
    chk("clrc mask",   64'(mask0),   64'h50);
    drv_driving = '0;
    cycle();

    // Stuck: channel 4 for 7 then 8 cycles
    drv_driving = 30'd1 << 4;
    repeat (7) cycle();
    chk("stuck7",  64'(stuck0), 64'd0);
    cycle();
    chk("stuck8",  64'(stuck0), 64'd1);
    drv_driving = '0;
    clr_diag    = 1'b1;
    cycle();
    clr_diag = 1'b0;
    chk("stuck clr", 64'(stuck0), 64'd0);

    // Source switch resets the run: ch4 x5 then ch9 x7 stays clear
    drv_driving = 30'd1 << 4;
    repeat (5) cycle();
    drv_driving = 30'd1 << 9;
    repeat (7) cycle();
    chk("switch stuck", 64'(stuck1), 64'd0);
    chk("switch src",   64'(bus1.ebus_src), 64'd9);
    cycle();
    chk("switch stuck8", 64'(stuck1), 64'd1);

    // Asynchronous reset in the middle of a contention
    drv_driving = 30'b110;
    cycle();
    chk("pre-rst conf", 64'(conflict0), 64'd1);
    #2;
    crobar_l = 1'b0;
    #1;
    chk("arst data",   64'(bus0.ebus_data),  64'd0);
    chk("arst par",    64'(bus0.ebus_par),   64'd1);
    chk("arst valid",  64'(bus0.ebus_valid), 64'd0);
    chk("arst src",    64'(bus0.ebus_src),   64'd0);
    chk("arst conf",   64'(conflict0),       64'd0);
    chk("arst sticky", 64'(sticky0),         64'd0);
    chk("arst mask",   64'(mask0),           64'd0);
    chk("arst cnt",    64'(cnt0),            64'd0);
    chk("arst stuck",  64'(stuck1),          64'd0);
    chk("arst data1",  64'(bus1.ebus_data),  64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ebus_arb_mux.md
# ebus_arb_mux

Parametrised, registered successor to the KL10 top-level EBUS data mux. It selects one of `N_DRV` module EBUS drivers onto the shared EBUS with fixed lowest-index priority, and registers the result. It also detects multi-driver contention and stuck drivers, and keeps sticky diagnostic state for the front end. It sits in the `kl10pv` top level between the per-module `tEBUSdriver` outputs and the `ebus_dNN_e_h` fan-out.

## Interface
Parameters:
- `N_DRV`, 30, number of driver channels (2..64)
- `WIDTH`, 36, EBUS data width
- `HOLD_IDLE`, 0, 0 = bus reads zero when no driver is active; 1 = hold the last driven value
- `CNT_W`, 8, width of the contention counter
- `STUCK_CYC`, 1024, consecutive cycles one source may drive before `stuck` is flagged (≥2)

Ports:
- `clk`  in  1  system clock
- `crobar_l`  in  1  asynchronous, active-low reset
- `drv_driving`  in  N_DRV  per-channel driving flag; bit i belongs to channel i
- `drv_data`  in  N_DRV*WIDTH  flattened driver data; channel i occupies `[i*WIDTH +: WIDTH]`
- `clr_diag`  in  1  synchronous clear of all diagnostic state
- `ebus_data`  out  WIDTH  registered EBUS data
- `ebus_valid`  out  1  registered: at least one driver was active
- `ebus_src`  out  clog2(N_DRV)  registered index of the winning channel
- `ebus_par`  out  1  registered odd parity over `ebus_data`
- `conflict`  out  1  one-cycle pulse, registered: more than one driver was active
- `conflict_sticky`  out  1  latched contention flag
- `conflict_mask`  out  N_DRV  copy of `drv_driving` from the first contention since the last clear
- `conflict_cnt`  out  CNT_W  saturating count of contention cycles
- `stuck`  out  1  latched: one source drove for `STUCK_CYC` consecutive cycles

## Operation
- Selection: the winner is the lowest i with `drv_driving[i]=1`. This matches the legacy ordering (apr before ccl … before vma).
- Idle cycle (no driver active):
  - `ebus_valid`←0.
  - `ebus_data`←0 if `HOLD_IDLE=0`; otherwise it keeps its previous value.
  - `ebus_src` keeps its previous value.
- Active cycle:
  - `ebus_data`←the winner's data, `ebus_valid`←1, `ebus_src`←the winner's index.
- `ebus_par` always equals `~^ebus_data`, so the total number of ones across data and parity is odd. It is registered alongside `ebus_data`.
- Contention (population count of `drv_driving` ≥2):
  - `conflict` pulses; the bus still carries the winner's data.
  - If `conflict_sticky=0`: `conflict_mask`←`drv_driving` and `conflict_sticky`←1.
  - If `conflict_sticky=1`: `conflict_mask` keeps the first captured value.
  - `conflict_cnt` increments and saturates at all-ones.
- Stuck detection:
  - An internal run counter counts consecutive active cycles that have the same winner index.
  - It resets to 1 when the winner changes or after an idle cycle, and resets to 0 when idle.
  - When the counter reaches `STUCK_CYC`, `stuck`←1 (latched). The counter saturates at `STUCK_CYC`.
- `clr_diag`: clears `conflict_sticky`, `conflict_mask`, `conflict_cnt` and `stuck`. It does not affect the data path or the run counter.
- `clr_diag` in the same cycle as a contention: the contention wins. `conflict_sticky`=1, `conflict_mask`=current `drv_driving`, `conflict_cnt`=1.
- `clr_diag` in the same cycle as the run counter reaching `STUCK_CYC`: `stuck`=1.

## Timing
- All outputs are registered with exactly one cycle of latency: inputs sampled at edge k appear after edge k.
- The path from `drv_*` to the output registers is purely combinational. There are no multicycle paths.
- Reset (`crobar_l`=0, asynchronous): every output goes to 0, except `ebus_par`=1, which is consistent with zero data. The run counter also resets to 0.
- Reset is released synchronously to logic. The first sample is taken at the first edge with `crobar_l`=1.
- Reset asserted mid-transfer: outputs go to their reset values immediately, with no clock required. All diagnostic state is lost.
- `conflict` is high for exactly one cycle per contending input cycle. It stays high for back-to-back cycles if contention persists.

## Test plan
- Single driver: `drv_driving`=bit 5, channel 5 data=36'o123456701234 → one cycle later `ebus_data`=36'o123456701234, `ebus_src`=5, `ebus_valid`=1, `conflict`=0, parity correct.
- Contention: bits 3 and 17 set for 1 cycle → `ebus_src`=3 with channel-3 data, `conflict` pulses once, `conflict_mask`=(1<<3)|(1<<17), `conflict_cnt`=1.
  - A subsequent contention on bits 0 and 1 leaves the mask unchanged and sets `conflict_cnt`=2.
- Idle and hold: drive channel 2 with 36'o777, then go idle.
  - With `HOLD_IDLE=0`: `ebus_data`=0, `ebus_par`=1, `ebus_valid`=0, `ebus_src`=2.
  - With `HOLD_IDLE=1`: `ebus_data`=36'o777.
- Counter saturation: with `CNT_W=4`, apply 20 contention cycles → `conflict_cnt`=15.
  - Pulse `clr_diag` alone → all diagnostics are 0.
  - `clr_diag` in the same cycle as a contention → `conflict_cnt`=1, `conflict_sticky`=1.
- Stuck: with `STUCK_CYC=8`, drive channel 4 for 7 cycles → `stuck`=0. The 8th cycle → `stuck`=1.
  - Switching the source at cycle 6 then driving channel 9 for 7 cycles → `stuck`=0.
- Asynchronous reset: assert `crobar_l` low between clock edges during contention → all outputs are 0 and `ebus_par`=1 before the next edge.
